// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache-miss memory arbiter: FSM states, grant owner
// and the line-offset width used to align pmem addresses.
package arb_types;

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        RESP
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    localparam int LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/mem_arbiter_line_adaptor.sv
// Converts between a full cache line and a sequence of pmem beats: counts
// beats, assembles read beats into the line register, serialises write beats.
module line_adaptor #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_wline,
    input  logic [LINE_W-1:0] wline,
    input  logic              beat_en,
    input  logic              is_write,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [LINE_W-1:0] line,
    output logic [BEAT_W-1:0] beat_out,
    output logic              last_beat
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
    assign beat_out  = line_q[int'(cnt_q) * BEAT_W +: BEAT_W];
    assign line      = line_q;

    // Beat slot k always maps to line bits [k*BEAT_W +: BEAT_W]; the counter
    // returns to zero after the last beat so the next burst starts at slot 0.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (load_wline) begin
            line_d = wline;
            cnt_d  = '0;
        end else if (beat_en) begin
            if (!is_write) begin
                line_d[int'(cnt_q) * BEAT_W +: BEAT_W] = beat_in;
            end
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache reads and D-cache reads/writebacks onto one 64-bit pmem
// port, running each line as a burst and returning it with a one-cycle resp.
module mem_arbiter
    import arb_types::*;
#(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

    arb_state_t        state_q, state_d;
    grant_t            owner_q, owner_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    grant_t            grant;
    logic              d_req;
    logic              in_burst;
    logic              load_wline;
    logic              beat_en;
    logic              is_write;
    logic [LINE_W-1:0] line;
    logic [BEAT_W-1:0] beat_out;
    logic              last_beat;

    assign d_req    = d_read | d_write;
    assign in_burst = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);
    assign beat_en  = in_burst & pmem_resp;
    assign is_write = (state_q == D_WR);

    line_adaptor #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_line_adaptor (
        .clk        (clk),
        .rst        (rst),
        .load_wline (load_wline),
        .wline      (d_wdata),
        .beat_en    (beat_en),
        .is_write   (is_write),
        .beat_in    (pmem_rdata),
        .line       (line),
        .beat_out   (beat_out),
        .last_beat  (last_beat)
    );

    // When both sides want memory, the side that did not win last time goes
    // next, so a stream of D misses cannot lock out instruction fetch.
    always_comb begin
        grant = GRANT_I;
        if (i_read && d_req) begin
            grant = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            grant = GRANT_D;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        load_wline   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_read || d_req) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    if (grant == GRANT_I) begin
                        addr_d  = i_address & ~OFFSET_MASK;
                        state_d = I_RD;
                    end else begin
                        addr_d = d_address & ~OFFSET_MASK;
                        if (d_write) begin
                            state_d    = D_WR;
                            load_wline = 1'b1;
                        end else begin
                            state_d = D_RD;
                        end
                    end
                end
            end
            I_RD, D_RD, D_WR: begin
                if (pmem_resp && last_beat) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= GRANT_I;
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
        end
    end

    // Everything below decodes registered state only, so a reset pulls the
    // strobes low immediately without waiting for a clock edge.
    assign pmem_read    = (state_q == I_RD) || (state_q == D_RD);
    assign pmem_write   = (state_q == D_WR);
    assign pmem_address = in_burst ? addr_q : '0;
    assign pmem_wdata   = is_write ? beat_out : '0;

    assign i_resp  = (state_q == RESP) && (owner_q == GRANT_I);
    assign d_resp  = (state_q == RESP) && (owner_q == GRANT_D);
    assign i_rdata = i_resp ? line : '0;
    assign d_rdata = d_resp ? line : '0;

    a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected lines, a monitor
// compares every resp, and a pmem model serves beats and checks writebacks.
module tb_mem_arbiter;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = LINE_W / BEAT_W;

    typedef struct {
        bit           is_wr;
        logic [255:0] data;
    } d_exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_address = '0;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_address = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;

    mem_arbiter #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial forever #5 clk = ~clk;

    int           vectors = 0;
    int           miscompares = 0;
    logic [255:0] i_exp_q[$];
    d_exp_t       d_exp_q[$];
    logic [287:0] wr_exp_q[$];
    bit           resp_order[$];
    logic [255:0] ref_mem[logic [31:0]];
    logic [255:0] pmem_mem[logic [31:0]];
    int           pmem_mode = 0;
    int           pat_idx = 0;
    bit           pattern[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic checkOutput(input string name, input logic [287:0] actual, input logic [287:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [255:0] init_line(input logic [31:0] addr);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = addr ^ (32'h9E37_79B9 * (k + 1));
        return r;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] addr);
        return ref_mem.exists(addr) ? ref_mem[addr] : init_line(addr);
    endfunction

    function automatic logic [255:0] pmem_line(input logic [31:0] addr);
        return pmem_mem.exists(addr) ? pmem_mem[addr] : init_line(addr);
    endfunction

    // One line request from either side; the expected response is queued at
    // issue time and the request is held until resp, then dropped a cycle later.
    task automatic applyStimulus(input bit side_d, input bit is_wr, input logic [31:0] addr,
                                 input logic [255:0] data, output int lat);
        logic [31:0] aligned;
        d_exp_t      e;
        bit          got;
        aligned = addr & ~32'h1F;
        if (!side_d) begin
            i_exp_q.push_back(ref_line(aligned));
            i_address = addr;
            i_read    = 1'b1;
        end else begin
            e.is_wr = is_wr;
            if (is_wr) begin
                ref_mem[aligned] = data;
                wr_exp_q.push_back({aligned, data});
                e.data = data;
            end else begin
                e.data = ref_line(aligned);
            end
            d_exp_q.push_back(e);
            d_address = addr;
            d_wdata   = data;
            d_write   = is_wr;
            d_read    = !is_wr;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
            got = side_d ? d_resp : i_resp;
        end
        if (!got) checkOutput(side_d ? "d_resp_timeout" : "i_resp_timeout", {287'd0, got}, 288'd1);
        @(posedge clk);
        #1;
        if (!side_d) i_read = 1'b0;
        else begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
    endtask

    task automatic applyReset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ctrl_outputs", {i_resp, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata}, '0);
        checkOutput("reset_i_rdata", i_rdata, '0);
        checkOutput("reset_d_rdata", d_rdata, '0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Response monitor: every resp pulse must match the head of its queue.
    initial forever begin
        d_exp_t e;
        @(negedge clk);
        if (rst) begin
            if (i_resp || d_resp) checkOutput("resp_exclusive", {287'd0, i_resp & d_resp}, '0);
            if (i_resp) begin
                resp_order.push_back(1'b0);
                if (i_exp_q.size() == 0) checkOutput("i_resp_unexpected", {287'd0, i_resp}, '0);
                else checkOutput("i_rdata", i_rdata, i_exp_q.pop_front());
            end
            if (d_resp) begin
                resp_order.push_back(1'b1);
                if (d_exp_q.size() == 0) checkOutput("d_resp_unexpected", {287'd0, d_resp}, '0);
                else begin
                    e = d_exp_q.pop_front();
                    if (!e.is_wr) checkOutput("d_rdata", d_rdata, e.data);
                end
            end
        end
    end

    // pmem model: decides pmem_resp each cycle, serves read beats and
    // reassembles write bursts, checking them against queued writebacks.
    initial begin
        int           beat_idx = 0;
        bit           in_burst = 1'b0;
        bit           go;
        logic [31:0]  burst_addr = '0;
        logic [255:0] cur_line;
        logic [255:0] wr_line = '0;
        forever begin
            @(negedge clk);
            if (!rst || !(pmem_read || pmem_write)) begin
                pmem_resp = 1'b0;
                beat_idx  = 0;
                in_burst  = 1'b0;
            end else begin
                if (!in_burst) begin
                    in_burst   = 1'b1;
                    burst_addr = pmem_address;
                    checkOutput("pmem_addr_align", {283'd0, pmem_address[4:0]}, '0);
                end else begin
                    checkOutput("pmem_addr_stable", {256'd0, pmem_address}, {256'd0, burst_addr});
                end
                case (pmem_mode)
                    0:       go = 1'b1;
                    1:       go = ($urandom_range(0, 2) != 0);
                    default: begin
                        go = pattern[pat_idx % 7];
                        pat_idx++;
                    end
                endcase
                cur_line   = pmem_line(pmem_address);
                pmem_rdata = cur_line[beat_idx*64 +: 64];
                pmem_resp  = go;
                if (go) begin
                    if (pmem_write) wr_line[beat_idx*64 +: 64] = pmem_wdata;
                    beat_idx++;
                    if (beat_idx == BEATS) begin
                        if (pmem_write) begin
                            if (wr_exp_q.size() == 0) checkOutput("pmem_write_unexpected", {287'd0, pmem_write}, '0);
                            else checkOutput("pmem_write_line", {burst_addr, wr_line}, wr_exp_q.pop_front());
                            pmem_mem[burst_addr] = wr_line;
                        end
                        beat_idx = 0;
                        in_burst = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           lat, i_lat, d_lat;
        logic [255:0] line1;
        logic [255:0] wline;

        applyReset();

        // Directed read with known beats and a cycle-by-cycle strobe check
        line1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        pmem_mem[32'h0000_1220] = line1;
        ref_mem[32'h0000_1220]  = line1;
        @(posedge clk);
        #1;
        i_address = 32'h0000_1234;
        i_read    = 1'b1;
        i_exp_q.push_back(line1);
        checkOutput("t1_pmem_read_c0", {287'd0, pmem_read}, '0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #2;
            checkOutput($sformatf("t1_pmem_read_c%0d", c), {287'd0, pmem_read}, {287'd0, c <= 4});
            if (c == 1) checkOutput("t1_pmem_address", {256'd0, pmem_address}, {256'd0, 32'h0000_1220});
            if (c == 5) checkOutput("t1_i_resp_c5", {287'd0, i_resp}, 288'd1);
        end
        @(posedge clk);
        #1;
        i_read = 1'b0;

        // Writeback with distinct beats, then read the line back
        wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        applyStimulus(1'b1, 1'b1, 32'h8000_0040, wline, lat);
        checkOutput("t2_write_latency", lat, 288'd5);
        applyStimulus(1'b1, 1'b0, 32'h8000_0044, '0, lat);

        // Simultaneous requests straight after reset: D first, then I
        applyReset();
        resp_order.delete();
        @(posedge clk);
        #1;
        fork
            applyStimulus(1'b0, 1'b0, 32'h0000_0300, '0, i_lat);
            applyStimulus(1'b1, 1'b0, 32'h8000_0300, '0, d_lat);
        join
        checkOutput("t3_d_latency", d_lat, 288'd5);
        checkOutput("t3_i_latency", i_lat, 288'd11);
        checkOutput("t3_order", {286'd0, resp_order[0], resp_order[1]}, 288'b10);

        // Back-to-back D misses while fetch waits: grants alternate
        resp_order.delete();
        fork
            applyStimulus(1'b0, 1'b0, 32'h0000_0400, '0, i_lat);
            begin
                for (int k = 0; k < 3; k++) applyStimulus(1'b1, k == 1, 32'h8000_0400 + 32'(k * 32), rand_line(), d_lat);
            end
        join
        checkOutput("t4_i_latency_bound", {287'd0, i_lat <= 2 * (1 + BEATS) + 1}, 288'd1);
        checkOutput("t4_order", {285'd0, resp_order[0], resp_order[1], resp_order[2]}, 288'b101);

        // Stalled read with a fixed pmem_resp gap pattern
        pmem_mode = 2;
        pat_idx   = 0;
        applyStimulus(1'b0, 1'b0, 32'h0000_2008, '0, lat);
        checkOutput("t5_gap_latency", lat, 288'd8);
        pmem_mode = 0;

        // Reset in the middle of a D read: strobe drops at once, no resp
        d_address = 32'h8000_0100;
        d_read    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        d_read = 1'b0;
        #1;
        checkOutput("t6_strobe_async_drop", {286'd0, pmem_read, pmem_write}, '0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6_outputs_in_reset", {i_resp, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata}, '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h8000_0100, '0, lat);
        checkOutput("t6_rerequest_latency", lat, 288'd5);

        // Randomised traffic from both sides with random pmem stalls
        pmem_mode = 1;
        fork
            begin
                for (int n = 0; n < 20; n++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus(1'b0, 1'b0, $urandom_range(0, 32'hFFF), '0, i_lat);
                end
            end
            begin
                for (int n = 0; n < 25; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus(1'b1, $urandom_range(0, 1) == 1,
                                  32'h8000_0000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31)),
                                  rand_line(), d_lat);
                end
            end
        join
        repeat (4) @(posedge clk);
        checkOutput("i_queue_drained", i_exp_q.size(), '0);
        checkOutput("d_queue_drained", d_exp_q.size(), '0);
        checkOutput("wr_queue_drained", wr_exp_q.size(), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
